// File: rtl/zeroriscy_bnn_engine_pkg.sv
// Shared definitions for the BNN execution unit: operation codes,
// FSM state encoding and the XNOR-popcount to signed term mapping.
package zeroriscy_bnn_engine_pkg;

    localparam logic [2:0] BNN_OP_LDW = 3'b000;
    localparam logic [2:0] BNN_OP_LDA = 3'b001;
    localparam logic [2:0] BNN_OP_CLR = 3'b010;
    localparam logic [2:0] BNN_OP_MAC = 3'b011;
    localparam logic [2:0] BNN_OP_ACT = 3'b100;
    localparam logic [2:0] BNN_OP_RDA = 3'b101;

    typedef enum logic [1:0] {
        BNN_IDLE,
        BNN_RUN,
        BNN_DONE
    } bnn_state_e;

    // Matching bits count +1, differing bits -1: term = 2*pc - 32.
    function automatic logic signed [6:0] bnn_term(input logic [5:0] pc);
        logic [6:0] t;
        t = {pc, 1'b0} - 7'd32;
        return $signed(t);
    endfunction

endpackage

// File: rtl/zeroriscy_bnn_popcnt.sv
// Combinational XNOR-popcount of two 32-bit words via an adder tree.
// Ports: i_w, i_a (32-bit operands), o_cnt (number of equal bits, 0..32).
module zeroriscy_bnn_popcnt (
    input  logic [31:0] i_w,
    input  logic [31:0] i_a,
    output logic [5:0]  o_cnt
);

    logic [31:0] w_x;
    logic [1:0]  w_l1 [16];
    logic [2:0]  w_l2 [8];
    logic [3:0]  w_l3 [4];
    logic [4:0]  w_l4 [2];

    always_comb begin
        w_x = ~(i_w ^ i_a);
        for (int i = 0; i < 16; i++) begin
            w_l1[i] = {1'b0, w_x[2*i]} + {1'b0, w_x[2*i+1]};
        end
        for (int i = 0; i < 8; i++) begin
            w_l2[i] = {1'b0, w_l1[2*i]} + {1'b0, w_l1[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            w_l3[i] = {1'b0, w_l2[2*i]} + {1'b0, w_l2[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            w_l4[i] = {1'b0, w_l3[2*i]} + {1'b0, w_l3[2*i+1]};
        end
        o_cnt = {1'b0, w_l4[0]} + {1'b0, w_l4[1]};
    end

endmodule

// File: rtl/zeroriscy_bnn_engine.sv
// Binarized-NN execution unit: weight/activation buffers, multi-cycle
// XNOR-popcount MAC into a signed accumulator, threshold activation.
// Ports: clk, rst_n (sync, active low), bnn_en_i, bnn_operator_i[2:0],
//        bnn_addr_i[31:0], bnn_data_i[31:0] in; bnn_result_o[31:0],
//        bnn_ready_o out (stalls EX exactly like the mult/div unit).
module zeroriscy_bnn_engine
    import zeroriscy_bnn_engine_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int ACC_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bnn_en_i,
    input  logic [2:0]  bnn_operator_i,
    input  logic [31:0] bnn_addr_i,
    input  logic [31:0] bnn_data_i,
    output logic [31:0] bnn_result_o,
    output logic        bnn_ready_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (ACC_W > 32) ? ACC_W : 32;

    bnn_state_e r_state;
    bnn_state_e w_state_nxt;

    logic [31:0] r_wbuf [DEPTH];
    logic [31:0] r_abuf [DEPTH];

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_sum;
    logic [AW-1:0]           r_idx;
    logic [AW-1:0]           r_base;
    logic [AW:0]             r_cnt;

    logic [AW:0]             w_n;
    logic [AW-1:0]           w_addr;
    logic [AW-1:0]           w_widx;
    logic [5:0]              w_pc;
    logic signed [6:0]       w_term;
    logic signed [ACC_W-1:0] w_acc_new;
    logic                    w_run_last;
    logic                    w_mac_start;
    logic                    w_idle_en;
    logic signed [CW-1:0]    w_cmp_acc;
    logic signed [CW-1:0]    w_cmp_thr;
    logic [31:0]             w_acc32;
    logic [31:0]             w_new32;
    logic                    w_unused_addr;

    assign w_addr        = bnn_addr_i[AW-1:0];
    assign w_unused_addr = ^bnn_addr_i[31:AW];

    // Word count clamps to the buffer depth.
    always_comb begin
        if (bnn_data_i[15:0] > 16'(DEPTH)) begin
            w_n = (AW+1)'(DEPTH);
        end else begin
            w_n = bnn_data_i[AW:0];
        end
    end

    // Weight index wraps naturally in AW bits; activations start at 0.
    assign w_widx = r_base + r_idx;

    zeroriscy_bnn_popcnt u_popcnt (
        .i_w   (r_wbuf[w_widx]),
        .i_a   (r_abuf[r_idx]),
        .o_cnt (w_pc)
    );

    assign w_term      = bnn_term(w_pc);
    assign w_acc_new   = r_acc + r_sum;
    assign w_run_last  = ({1'b0, r_idx} == r_cnt - (AW+1)'(1));
    assign w_idle_en   = bnn_en_i && (r_state == BNN_IDLE);
    assign w_mac_start = w_idle_en && (bnn_operator_i == BNN_OP_MAC)
                         && (w_n != '0);

    assign w_cmp_acc = CW'(r_acc);
    assign w_cmp_thr = CW'($signed(bnn_data_i));
    assign w_acc32   = 32'(r_acc);
    assign w_new32   = 32'(w_acc_new);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= BNN_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; dropping enable abandons an in-flight MAC.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            BNN_IDLE: begin
                if (w_mac_start) begin
                    w_state_nxt = BNN_RUN;
                end
            end
            BNN_RUN: begin
                if (!bnn_en_i) begin
                    w_state_nxt = BNN_IDLE;
                end else if (w_run_last) begin
                    w_state_nxt = BNN_DONE;
                end
            end
            BNN_DONE: w_state_nxt = BNN_IDLE;
            default:  w_state_nxt = BNN_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bnn_ready_o  = 1'b0;
        bnn_result_o = '0;
        if (bnn_en_i) begin
            unique case (r_state)
                BNN_IDLE: begin
                    bnn_ready_o = 1'b1;
                    unique case (bnn_operator_i)
                        BNN_OP_MAC: begin
                            if (w_n != '0) begin
                                bnn_ready_o = 1'b0;
                            end else begin
                                bnn_result_o = w_acc32;
                            end
                        end
                        BNN_OP_ACT: begin
                            bnn_result_o = (w_cmp_acc >= w_cmp_thr)
                                           ? 32'd1 : 32'd0;
                        end
                        BNN_OP_RDA: bnn_result_o = w_acc32;
                        default:    bnn_result_o = '0;
                    endcase
                end
                BNN_RUN:  bnn_ready_o = 1'b0;
                BNN_DONE: begin
                    bnn_ready_o  = 1'b1;
                    bnn_result_o = w_new32;
                end
                default: bnn_ready_o = 1'b0;
            endcase
        end
    end

    // Buffers are plain flop arrays without reset.
    always_ff @(posedge clk) begin
        if (w_idle_en && bnn_operator_i == BNN_OP_LDW) begin
            r_wbuf[w_addr] <= bnn_data_i;
        end
        if (w_idle_en && bnn_operator_i == BNN_OP_LDA) begin
            r_abuf[w_addr] <= bnn_data_i;
        end
    end

    // Datapath: counters, running sum and accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_sum  <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_base <= '0;
        end else begin
            unique case (r_state)
                BNN_IDLE: begin
                    if (w_idle_en && bnn_operator_i == BNN_OP_CLR) begin
                        r_acc <= '0;
                    end
                    if (w_mac_start) begin
                        r_base <= w_addr;
                        r_cnt  <= w_n;
                        r_idx  <= '0;
                        r_sum  <= '0;
                    end
                end
                BNN_RUN: begin
                    if (bnn_en_i) begin
                        r_sum <= r_sum + ACC_W'(w_term);
                        r_idx <= r_idx + AW'(1);
                    end
                end
                BNN_DONE: begin
                    if (bnn_en_i) begin
                        r_acc <= w_acc_new;
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

endmodule
